// File: rtl/arb_pkg.sv
// Shared definitions for the bus arbiters: FSM state encoding, reset weight
// and the index-width helper used to size master index ports.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_e;

  localparam int DEFAULT_WEIGHT = 1;

  // Width of an index that can address n masters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first: returns the first set bit of mask, scanning upward
// from start and wrapping around. Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk the N positions starting at start; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && mask[(int'(start) + k) % N]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter granting the shared bus at burst granularity.
// A master keeps the grant for up to its weight in beats or until it flags
// last; every release is followed by a single idle turnaround cycle.
module wrr_burst_arbiter #(
  parameter int N              = 4,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_WEIGHT = arb_pkg::DEFAULT_WEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          last,
  input  logic                  beat,
  input  logic                  cfg_wr,
  input  logic [$clog2(N)-1:0]  cfg_idx,
  input  logic [WEIGHT_W-1:0]   cfg_weight,
  output logic [N-1:0]          gnt,
  output logic                  gnt_valid,
  output logic [$clog2(N)-1:0]  gnt_idx,
  output logic [WEIGHT_W-1:0]   credit
);

  import arb_pkg::*;

  localparam int IDX_W = $clog2(N);

  arb_state_e          state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] weight_q [N];

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                release_burst;

  // A programmed weight of zero still allows one beat per grant.
  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  rr_pick #(.N(N)) u_pick (
    .mask  (req),
    .start (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: arbitrate in IDLE/GAP, count beats and release in GRANT.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_idx_d     = gnt_idx_q;
    credit_d      = credit_q;
    rr_ptr_d      = rr_ptr_q;
    release_burst = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        gnt_d     = '0;
        gnt_idx_d = '0;
        credit_d  = '0;
        state_d   = IDLE;
        if (pick_found) begin
          state_d         = GRANT;
          gnt_d[pick_idx] = 1'b1;
          gnt_idx_d       = pick_idx;
          // Registered weight: a write landing on this same edge is not seen.
          credit_d        = eff_weight(weight_q[pick_idx]);
        end
      end
      GRANT: begin
        release_burst = !req[gnt_idx_q] ||
                        (beat && (last[gnt_idx_q] || credit_q == WEIGHT_W'(1)));
        if (release_burst) begin
          state_d   = GAP;
          gnt_d     = '0;
          gnt_idx_d = '0;
          credit_d  = '0;
          // Released master drops to lowest priority for the next pick.
          rr_ptr_d  = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        end else if (beat) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
        credit_d  = '0;
      end
    endcase
  end

  // Arbiter state and registered grant outputs.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      credit_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      credit_q  <= credit_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Per-master weight registers; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    // NOTE: this small register file is reset on purpose, since software may
    // rely on every master starting at the default weight.
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
      end
    end else if (cfg_wr && (int'(cfg_idx) < N)) begin
      weight_q[cfg_idx] <= cfg_weight;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign credit    = credit_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: a cycle-by-cycle vector table for
// the basic rotation and credit countdown, then hand-written sequences for
// last, req drop, live weight writes and reset mid-burst.
module tb_wrr_burst_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic          beat;
  logic          cfg_wr;
  logic [1:0]    cfg_idx;
  logic [WW-1:0] cfg_weight;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [1:0]    gnt_idx;
  logic [WW-1:0] credit;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          beat;
    logic          cfg_wr;
    logic [1:0]    cfg_idx;
    logic [WW-1:0] cfg_weight;
    logic [N-1:0]  exp_gnt;
    logic [1:0]    exp_idx;
    logic [WW-1:0] exp_credit;
  } vec_t;

  vec_t vecs[$];

  wrr_burst_arbiter #(.N(N), .WEIGHT_W(WW), .DEFAULT_WEIGHT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .last       (last),
    .beat       (beat),
    .cfg_wr     (cfg_wr),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .credit     (credit)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] eg,
                            input logic [1:0] ei, input logic [WW-1:0] ec);
    check({tag, " gnt"},       32'(gnt),       32'(eg));
    check({tag, " gnt_valid"}, 32'(gnt_valid), 32'(|eg));
    check({tag, " gnt_idx"},   32'(gnt_idx),   32'(ei));
    check({tag, " credit"},    32'(credit),    32'(ec));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ls,
                              input logic bt, input logic cw, input logic [1:0] ci,
                              input logic [WW-1:0] cwt, input logic [N-1:0] eg,
                              input logic [1:0] ei, input logic [WW-1:0] ec);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.beat = bt;
    v.cfg_wr = cw; v.cfg_idx = ci; v.cfg_weight = cwt;
    v.exp_gnt = eg; v.exp_idx = ei; v.exp_credit = ec;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; beat = 1'b0; cfg_wr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_weight(input logic [1:0] idx, input logic [WW-1:0] w);
    cfg_wr = 1'b1; cfg_idx = idx; cfg_weight = w;
    tick();
    cfg_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; beat = 1'b0;
    cfg_wr = 1'b0; cfg_idx = '0; cfg_weight = '0;

    // Rows: inputs applied before an edge, outputs expected after it.
    // Two masters at weight 1, beat always high: 0 and 2 alternate with gaps.
    vecs.push_back(mk(1, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0100, 2, 1));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0100, 2, 1));
    // Weight 3 on master 1, lone requester: credit 3,2,1, gap, regrant at 3.
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 3, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0010, 1, 3));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0010, 1, 2));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0010, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0010, 1, 3));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0010, 1, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; last = vecs[i].last; beat = vecs[i].beat;
      cfg_wr = vecs[i].cfg_wr; cfg_idx = vecs[i].cfg_idx; cfg_weight = vecs[i].cfg_weight;
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_idx, vecs[i].exp_credit);
    end

    // last on the 2nd beat of master 2 (weight 5); master 3 goes next.
    do_reset();
    write_weight(2'd2, 4'd5);
    req = 4'b1100; beat = 1'b0;
    tick(); expect_out("last grant2", 4'b0100, 2, 5);
    last = 4'b0100; beat = 1'b0;
    tick(); expect_out("last no beat", 4'b0100, 2, 5);
    last = 4'b0000; beat = 1'b1;
    tick(); expect_out("last beat1", 4'b0100, 2, 4);
    last = 4'b0100; beat = 1'b1;
    tick(); expect_out("last release", 4'b0000, 0, 0);
    last = 4'b0000; beat = 1'b0;
    tick(); expect_out("last next m3", 4'b1000, 3, 1);

    // Master 0 drops req with credit 4; pointer moves to 1, so 1 beats 3.
    do_reset();
    write_weight(2'd0, 4'd4);
    req = 4'b1011; beat = 1'b0;
    tick(); expect_out("drop grant0", 4'b0001, 0, 4);
    req = 4'b1010; beat = 1'b1;
    tick(); expect_out("drop release", 4'b0000, 0, 0);
    beat = 1'b0;
    tick(); expect_out("drop next m1", 4'b0010, 1, 1);

    // Weight write during a live burst does not touch the running credit.
    do_reset();
    write_weight(2'd0, 4'd6);
    req = 4'b0001; beat = 1'b0;
    tick(); expect_out("cfg grant6", 4'b0001, 0, 6);
    cfg_wr = 1'b1; cfg_idx = 2'd0; cfg_weight = 4'd2; beat = 1'b1;
    tick(); expect_out("cfg live wr", 4'b0001, 0, 5);
    cfg_wr = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      tick(); expect_out($sformatf("cfg count%0d", k), 4'b0001, 0, 4'(k));
    end
    tick(); expect_out("cfg 6th beat", 4'b0000, 0, 0);
    // Write landing on the grant-load edge: the grant keeps the old value 2.
    cfg_wr = 1'b1; cfg_idx = 2'd0; cfg_weight = 4'd7; beat = 1'b0;
    tick(); expect_out("cfg load old", 4'b0001, 0, 2);
    // Weight 0 becomes effective credit 1 on the following grant.
    cfg_wr = 1'b1; cfg_idx = 2'd0; cfg_weight = 4'd0; beat = 1'b1; last = 4'b0001;
    tick(); expect_out("cfg w0 release", 4'b0000, 0, 0);
    cfg_wr = 1'b0; beat = 1'b0; last = 4'b0000;
    tick(); expect_out("cfg w0 credit1", 4'b0001, 0, 1);

    // Reset while master 1 is mid-burst with the pointer away from zero.
    do_reset();
    write_weight(2'd1, 4'd3);
    req = 4'b1111; beat = 1'b0;
    tick(); expect_out("rst grant0", 4'b0001, 0, 1);
    beat = 1'b1;
    tick(); expect_out("rst gap", 4'b0000, 0, 0);
    beat = 1'b0;
    tick(); expect_out("rst grant1", 4'b0010, 1, 3);
    beat = 1'b1;
    tick(); expect_out("rst beat", 4'b0010, 1, 2);
    rst = 1'b1;
    tick(); expect_out("rst clear", 4'b0000, 0, 0);
    rst = 1'b0; beat = 1'b0;
    tick(); expect_out("rst regrant0", 4'b0001, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream bus among N masters at burst granularity.
- Each master holds its grant for up to its programmed weight in beats, or until it signals last, whichever comes first. The grant then rotates.
- Sits between the master request ports and the shared slave-side mux. gnt/gnt_idx drive the mux select; beat is the slave's per-beat accept.

Parameters:
N, 4, number of masters (2..16)
WEIGHT_W, 4, width of each per-master weight field (max burst credit = 2^WEIGHT_W - 1)
DEFAULT_WEIGHT, 1, reset value of every weight register

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  N  per-master request, level, held while the master wants the bus
last  input  N  per-master end-of-burst flag; qualified only with beat while granted
beat  input  1  slave accepted one beat this cycle from the granted master
cfg_wr  input  1  write strobe for weight registers
cfg_idx  input  $clog2(N)  master index to configure
cfg_weight  input  WEIGHT_W  weight value to write
gnt  output  N  one-hot grant, registered
gnt_valid  output  1  equals |gnt
gnt_idx  output  $clog2(N)  index of granted master; 0 when gnt_valid=0
credit  output  WEIGHT_W  beats remaining in the current grant; 0 when idle

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: gnt=0, gnt_valid=0, gnt_idx=0, credit=0, FSM=IDLE, rr_ptr=0, all weights=DEFAULT_WEIGHT.
- Reset asserted mid-burst clears the grant on the next edge. No beat is counted in that cycle.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If |req, pick the first set req scanning from rr_ptr upward with wrap-around.
  - Next cycle: gnt=onehot(sel), gnt_idx=sel, credit=eff_weight(sel), state -> GRANT.
  - Request-to-grant latency is 1 cycle.
- eff_weight(i): weight[i]; a stored 0 is treated as 1.
- GRANT, per cycle, with current master c:
  - req[c]=0: release, no beat counted.
  - beat=1 and last[c]=1: release.
  - beat=1 and credit=1: release (credit exhausted).
  - beat=1 otherwise: credit <= credit-1, hold grant.
  - beat=0: hold grant, credit unchanged.
  - last[c] without beat is ignored.
  - last and credit exhaustion in the same cycle cause a single release.
- Release:
  - Next cycle: gnt=0, credit=0, rr_ptr <= (c+1) mod N, state -> GAP.
  - GAP is exactly one cycle with no grant. It is the mux turnaround; arbitration runs at the end of GAP.
  - GAP -> GRANT if any req (same selection rule as IDLE), else -> IDLE.
  - Back-to-back bursts therefore show gnt low for exactly 1 cycle.
- The released master re-requesting immediately gets the lowest rotation priority. With a single requester, it is re-granted after the gap.
- Weight registers:
  - cfg_wr writes weight[cfg_idx] at the clock edge.
  - A write to the currently granted master does not change the live credit. The new value applies from that master's next grant.
  - A write in the same cycle as a grant load to the same index: the grant uses the old value.
  - cfg_idx >= N: write ignored.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid=0 implies credit=0.
  - A master receives at most eff_weight beats per grant.
  - Any requester holding req is granted within (N-1) bursts of other masters plus their gaps.

Decomposition:
- Package arb_pkg: state enum (IDLE, GRANT, GAP), DEFAULT_WEIGHT, index width helper constant.
- Sub-module rr_pick: combinational rotate-from-pointer find-first. Inputs mask[N] and start idx; outputs idx and found. Reused by other arbiters in the codebase.

Test Plan:
- Reset then req=4'b0101, weights all 1, beat held high:
  - gnt=0001 at cycle 1, gap at cycle 2, gnt=0100 at cycle 3, gap, gnt=0001 again.
  - Alternates 0/2 with 1-cycle gaps.
- weight[1]=3, only req[1] high, beat continuous, last never set:
  - gnt=0010 for exactly 3 beat cycles, credit steps 3,2,1.
  - Then 1 gap cycle, then re-grant with credit=3.
- weight[2]=5, master 2 asserts last on its 2nd beat:
  - Release after 2 beats, gnt=0 next cycle.
  - Master 3 (also requesting) is granted the cycle after the gap.
- Granted master 0 drops req mid-burst with credit=4:
  - gnt=0 next cycle, no beat counted.
  - rr_ptr=1, so master 1 beats pending master 3 on re-arbitration.
- cfg_wr weight[0]=2 while master 0 is granted with credit=6:
  - Burst runs to 6 beats.
  - Next grant of master 0 loads credit=2.
  - Separately, writing weight 0 yields credit=1.
- All 4 masters requesting, then rst pulsed mid-burst:
  - gnt=0 and credit=0 on the next edge.
  - After release of reset, master 0 is granted first (rr_ptr=0).
